// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: funct3 size codes,
// response-ID encodings, lane count, and lane-mask/store-data/legality helpers.
package dmem_pkg;

    localparam int LANES = 4;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic {
        PORT_CORE   = 1'b0,
        PORT_LOADER = 1'b1
    } port_e;

    // Unsigned sizes are load-only; H needs even address, W word-aligned.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3,
                                      input logic [1:0] off);
        logic ok;
        case (f3)
            F3_B:          ok = 1'b1;
            F3_BU:         ok = !we;
            F3_H:          ok = !off[0];
            F3_HU:         ok = !off[0] && !we;
            F3_W:          ok = (off == 2'b00);
            default:       ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Size is carried in funct3[1:0]: 00 byte, 01 half, 10 word.
    function automatic logic [LANES-1:0] lane_mask(input logic [2:0] f3,
                                                   input logic [1:0] off);
        logic [LANES-1:0] m;
        case (f3[1:0])
            2'b00:   m = 4'b0001 << off;
            2'b01:   m = off[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Replicate the store operand so every candidate lane sees its byte.
    function automatic logic [8*LANES-1:0] store_data(input logic [2:0] f3,
                                                      input logic [31:0] wdata);
        logic [8*LANES-1:0] d;
        case (f3[1:0])
            2'b00:   d = {4{wdata[7:0]}};
            2'b01:   d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/dmem_align.sv
// Load formatter: picks the addressed byte/half out of the four lane outputs
// and sign- or zero-extends it according to funct3.
module dmem_align
    import dmem_pkg::*;
(
    input  logic [8*LANES-1:0] lane_dout_i,
    input  logic [1:0]         off_i,
    input  logic [2:0]         funct3_i,
    output logic [31:0]        data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sext;

    // Lane selection and extension; funct3[2] marks the unsigned variants.
    always_comb begin
        byte_sel = lane_dout_i[{off_i, 3'b000} +: 8];
        half_sel = off_i[1] ? lane_dout_i[31:16] : lane_dout_i[15:0];
        sext     = !funct3_i[2];
        case (funct3_i[1:0])
            2'b00:   data_o = {{24{byte_sel[7] & sext}}, byte_sel};
            2'b01:   data_o = {{16{half_sel[15] & sext}}, half_sel};
            default: data_o = lane_dout_i;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: arbitrates core and loader onto four byte-lane
// BRAMs, drives registered lane strobes, returns formatted load data one
// cycle after the grant.
// Build option: DMEM_CTRL_RR_EN selects round-robin arbitration; without it
// the core has fixed priority and no pointer register exists.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 13
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  C_VALID,
    output logic                  C_READY,
    input  logic                  C_WE,
    input  logic [2:0]            C_FUNCT3,
    input  logic [ADDR_WIDTH-1:0] C_ADDR,
    input  logic [31:0]           C_WDATA,
    input  logic                  L_VALID,
    output logic                  L_READY,
    input  logic                  L_WE,
    input  logic [2:0]            L_FUNCT3,
    input  logic [ADDR_WIDTH-1:0] L_ADDR,
    input  logic [31:0]           L_WDATA,
    output logic                  RSP_VALID,
    output logic                  RSP_ID,
    output logic                  RSP_ERR,
    output logic [31:0]           RSP_RDATA,
    output logic [ADDR_WIDTH-1:0] LANE_ADDR,
    output logic [LANES-1:0]      LANE_WE,
    output logic [LANES-1:0]      LANE_RE,
    output logic [8*LANES-1:0]    LANE_DIN,
    input  logic [8*LANES-1:0]    LANE_DOUT
);

    logic                  grant_c, grant_l, sel_valid, sel_we, sel_legal;
    logic [2:0]            sel_f3;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [31:0]           sel_wdata, align_data;
    logic [LANES-1:0]      sel_mask;

    logic [ADDR_WIDTH-1:0] lane_addr_q, lane_addr_d;
    logic [LANES-1:0]      lane_we_q, lane_we_d, lane_re_q, lane_re_d;
    logic [8*LANES-1:0]    lane_din_q, lane_din_d;
    logic                  pend_v_q, pend_v_d, pend_err_q, pend_err_d;
    logic                  pend_we_q, pend_we_d;
    port_e                 pend_id_q, pend_id_d;
    logic [1:0]            pend_off_q, pend_off_d;
    logic [2:0]            pend_f3_q, pend_f3_d;
    logic                  rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;

`ifdef DMEM_CTRL_RR_EN
    port_e ptr_q;

    // Core wins when alone or when the pointer favours it.
    always_comb grant_c = C_VALID && (!L_VALID || ptr_q == PORT_CORE);
`else
    // Fixed priority: the loader only gets idle core cycles.
    always_comb grant_c = C_VALID;
`endif

    // Loader grant, READY gating and request mux.
    always_comb begin
        grant_l   = L_VALID && !grant_c;
        C_READY   = grant_c && !RST;
        L_READY   = grant_l && !RST;
        sel_valid = grant_c || grant_l;
        sel_we    = grant_l ? L_WE     : C_WE;
        sel_f3    = grant_l ? L_FUNCT3 : C_FUNCT3;
        sel_addr  = grant_l ? L_ADDR   : C_ADDR;
        sel_wdata = grant_l ? L_WDATA  : C_WDATA;
        sel_legal = f3_legal(sel_we, sel_f3, sel_addr[1:0]);
        sel_mask  = lane_mask(sel_f3, sel_addr[1:0]);
    end

    dmem_align u_align (
        .lane_dout_i (LANE_DOUT),
        .off_i       (pend_off_q),
        .funct3_i    (pend_f3_q),
        .data_o      (align_data)
    );

    // Next-state: lane strobes for this grant, response for last cycle's grant.
    always_comb begin
        lane_addr_d = lane_addr_q;
        lane_we_d   = '0;
        lane_re_d   = '0;
        lane_din_d  = '0;
        pend_v_d    = sel_valid;
        pend_id_d   = grant_l ? PORT_LOADER : PORT_CORE;
        pend_err_d  = !sel_legal;
        pend_we_d   = sel_we;
        pend_off_d  = sel_addr[1:0];
        pend_f3_d   = sel_f3;
        rsp_valid_d = pend_v_q;
        rsp_id_d    = pend_v_q && (pend_id_q == PORT_LOADER);
        rsp_err_d   = pend_v_q && pend_err_q;
        rsp_rdata_d = (pend_v_q && !pend_err_q && !pend_we_q) ? align_data : 32'h0;
        if (sel_valid) begin
            lane_addr_d = {sel_addr[ADDR_WIDTH-1:2], 2'b00};
            if (sel_legal && sel_we) begin
                lane_we_d  = sel_mask;
                lane_din_d = store_data(sel_f3, sel_wdata);
            end else if (sel_legal) begin
                lane_re_d  = sel_mask;
            end
        end
    end

    // State update; reset kills this cycle's strobes and any pending response.
    always_ff @(posedge CLK) begin
        if (RST) begin
            lane_addr_q <= '0;
            lane_we_q   <= '0;
            lane_re_q   <= '0;
            lane_din_q  <= '0;
            pend_v_q    <= 1'b0;
            pend_id_q   <= PORT_CORE;
            pend_err_q  <= 1'b0;
            pend_we_q   <= 1'b0;
            pend_off_q  <= 2'b00;
            pend_f3_q   <= 3'b000;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
`ifdef DMEM_CTRL_RR_EN
            ptr_q       <= PORT_CORE;
`endif
        end else begin
            lane_addr_q <= lane_addr_d;
            lane_we_q   <= lane_we_d;
            lane_re_q   <= lane_re_d;
            lane_din_q  <= lane_din_d;
            pend_v_q    <= pend_v_d;
            pend_id_q   <= pend_id_d;
            pend_err_q  <= pend_err_d;
            pend_we_q   <= pend_we_d;
            pend_off_q  <= pend_off_d;
            pend_f3_q   <= pend_f3_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef DMEM_CTRL_RR_EN
            if (C_VALID && L_VALID)
                ptr_q <= grant_c ? PORT_LOADER : PORT_CORE;
`endif
        end
    end

    assign LANE_ADDR = lane_addr_q;
    assign LANE_WE   = lane_we_q;
    assign LANE_RE   = lane_re_q;
    assign LANE_DIN  = lane_din_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_ID    = rsp_id_q;
    assign RSP_ERR   = rsp_err_q;
    assign RSP_RDATA = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: negedge byte-lane BRAM models, a byte-addressed
// reference memory model, directed literal checks and randomized traffic.
module tb_dmem_ctrl;

    localparam int AW = 13;

    logic          CLK = 1'b0;
    logic          RST;
    logic          C_VALID, C_READY, C_WE, L_VALID, L_READY, L_WE;
    logic [2:0]    C_FUNCT3, L_FUNCT3;
    logic [AW-1:0] C_ADDR, L_ADDR, LANE_ADDR;
    logic [31:0]   C_WDATA, L_WDATA, RSP_RDATA, LANE_DIN, LANE_DOUT;
    logic          RSP_VALID, RSP_ID, RSP_ERR;
    logic [3:0]    LANE_WE, LANE_RE;

    int errors = 0;
    int checks = 0;

    dmem_ctrl #(.ADDR_WIDTH(AW)) dut (
        .CLK(CLK), .RST(RST),
        .C_VALID(C_VALID), .C_READY(C_READY), .C_WE(C_WE), .C_FUNCT3(C_FUNCT3),
        .C_ADDR(C_ADDR), .C_WDATA(C_WDATA),
        .L_VALID(L_VALID), .L_READY(L_READY), .L_WE(L_WE), .L_FUNCT3(L_FUNCT3),
        .L_ADDR(L_ADDR), .L_WDATA(L_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_ID(RSP_ID), .RSP_ERR(RSP_ERR), .RSP_RDATA(RSP_RDATA),
        .LANE_ADDR(LANE_ADDR), .LANE_WE(LANE_WE), .LANE_RE(LANE_RE),
        .LANE_DIN(LANE_DIN), .LANE_DOUT(LANE_DOUT)
    );

    initial forever #5 CLK = ~CLK;

    // Byte-lane BRAMs acting on the falling edge.
    bit [7:0] lane_mem [4][2048];
    bit [7:0] lane_q [4];
    always @(negedge CLK) begin
        for (int i = 0; i < 4; i++) begin
            if (LANE_WE[i] === 1'b1) lane_mem[i][LANE_ADDR[12:2]] <= LANE_DIN[8*i +: 8];
            if (LANE_RE[i] === 1'b1) lane_q[i] <= lane_mem[i][LANE_ADDR[12:2]];
        end
    end
    assign LANE_DOUT = {lane_q[3], lane_q[2], lane_q[1], lane_q[0]};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit [7:0] ref_mem [8192];

    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic bit legal(input logic we, input logic [2:0] f3, input logic [12:0] a);
        if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 0;
        if (we && (f3 == 3'd4 || f3 == 3'd5)) return 0;
        return (int'(a) % size_of(f3)) == 0;
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [12:0] a);
        int sz = size_of(f3);
        logic [31:0] v = 0;
        for (int j = 0; j < sz; j++) v = v | (32'(ref_mem[int'(a) + j]) << (8 * j));
        if ((f3 == 3'd0 || f3 == 3'd1) && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
        return v;
    endfunction

    logic [3:0]  exp_we = 0, exp_re = 0;
    logic [12:0] exp_addr = 0;
    logic [31:0] exp_din = 0, exp_rdata = 0;
    bit          exp_rv = 0, exp_rid = 0, exp_rerr = 0;
    bit          pend_v = 0, pend_id = 0, pend_err = 0, pref_l = 0;
    logic [31:0] pend_data = 0;

    // One compare process: check last posedge's outputs, then advance the model
    // with the inputs that the next posedge will sample.
    always @(negedge CLK) begin
        logic [3:0]  n_we, n_re;
        logic [12:0] n_addr, a;
        logic [31:0] n_din, n_rdata, wd;
        logic [2:0]  f3;
        bit          n_rv, n_rid, n_rerr, gc, gl, we;
        int          sz;

        chk("rsp_valid", RSP_VALID, exp_rv);
        if (exp_rv) begin
            chk("rsp_id", RSP_ID, exp_rid);
            chk("rsp_err", RSP_ERR, exp_rerr);
            chk("rsp_rdata", RSP_RDATA, exp_rdata);
        end
        chk("lane_we", LANE_WE, exp_we);
        chk("lane_re", LANE_RE, exp_re);
        if ((exp_we | exp_re) != 0) chk("lane_addr", LANE_ADDR, exp_addr);
        if (exp_we != 0) chk("lane_din", LANE_DIN, exp_din);

        n_we = 0; n_re = 0; n_din = 0; n_addr = 0;
        n_rv = 0; n_rid = 0; n_rerr = 0; n_rdata = 0;
        gc = 0; gl = 0;
        if (RST) begin
            pend_v = 0;
            pref_l = 0;
        end else begin
            n_rv = pend_v; n_rid = pend_id; n_rerr = pend_err; n_rdata = pend_data;
            if (C_VALID && L_VALID) begin
`ifdef DMEM_CTRL_RR_EN
                gl = pref_l;
                pref_l = !gl;
`else
                gl = 0;
`endif
                gc = !gl;
            end else begin
                gc = C_VALID;
                gl = L_VALID;
            end
            pend_v = gc || gl;
            if (pend_v) begin
                we = gl ? L_WE : C_WE;
                f3 = gl ? L_FUNCT3 : C_FUNCT3;
                a  = gl ? L_ADDR : C_ADDR;
                wd = gl ? L_WDATA : C_WDATA;
                pend_id = gl;
                pend_err = !legal(we, f3, a);
                pend_data = 0;
                n_addr = a & 13'h1FFC;
                if (!pend_err) begin
                    sz = size_of(f3);
                    for (int j = 0; j < sz; j++) begin
                        if (we) n_we[(int'(a) + j) % 4] = 1'b1;
                        else    n_re[(int'(a) + j) % 4] = 1'b1;
                    end
                    if (we) begin
                        for (int i = 0; i < 4; i++) n_din[8*i +: 8] = wd[8*(i % sz) +: 8];
                        for (int j = 0; j < sz; j++) ref_mem[int'(a) + j] = wd[8*j +: 8];
                    end else begin
                        pend_data = load_val(f3, a);
                    end
                end
            end
        end
        chk("c_ready", C_READY, gc);
        chk("l_ready", L_READY, gl);
        exp_we = n_we; exp_re = n_re; exp_addr = n_addr; exp_din = n_din;
        exp_rv = n_rv; exp_rid = n_rid; exp_rerr = n_rerr; exp_rdata = n_rdata;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue_c(input bit we, input bit [2:0] f3, input bit [12:0] a, input bit [31:0] d);
        C_VALID = 1; C_WE = we; C_FUNCT3 = f3; C_ADDR = a; C_WDATA = d; L_VALID = 0;
        step();
        C_VALID = 0;
    endtask

    bit [3:0] exp_ids;
    bit [2:0] legal_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    initial begin
        RST = 1;
        C_VALID = 0; C_WE = 0; C_FUNCT3 = 0; C_ADDR = 0; C_WDATA = 0;
        L_VALID = 0; L_WE = 0; L_FUNCT3 = 0; L_ADDR = 0; L_WDATA = 0;
        repeat (3) step();
        C_VALID = 1; L_VALID = 1;
        #1;
        chk("rst_c_ready", C_READY, 0);
        chk("rst_l_ready", L_READY, 0);
        chk("rst_lane_we", LANE_WE, 0);
        chk("rst_lane_re", LANE_RE, 0);
        chk("rst_lane_addr", LANE_ADDR, 0);
        chk("rst_lane_din", LANE_DIN, 0);
        chk("rst_rsp", {RSP_VALID, RSP_ID, RSP_ERR}, 0);
        chk("rst_rdata", RSP_RDATA, 0);
        step();
        C_VALID = 0; L_VALID = 0; RST = 0;
        step();

        issue_c(1, 3'd2, 13'h010, 32'hDEADBEEF);
        chk("sw_we", LANE_WE, 4'b1111);
        issue_c(0, 3'd2, 13'h010, 0);
        chk("lw_re", LANE_RE, 4'b1111);
        step();
        chk("lw_data", RSP_RDATA, 32'hDEADBEEF);

        issue_c(1, 3'd0, 13'h013, 32'h80);
        chk("sb_we", LANE_WE, 4'b1000);
        issue_c(0, 3'd0, 13'h013, 0);
        step();
        chk("lb_data", RSP_RDATA, 32'hFFFFFF80);
        issue_c(0, 3'd4, 13'h013, 0);
        step();
        chk("lbu_data", RSP_RDATA, 32'h00000080);

        issue_c(1, 3'd1, 13'h012, 32'h1234);
        chk("sh_we", LANE_WE, 4'b1100);
        issue_c(0, 3'd5, 13'h012, 0);
        step();
        chk("lhu_data", RSP_RDATA, 32'h00001234);
        issue_c(0, 3'd2, 13'h010, 0);
        step();
        chk("lw_merge", RSP_RDATA, 32'h1234BEEF);

        issue_c(0, 3'd2, 13'h011, 0);
        chk("mis_strobe", {LANE_WE, LANE_RE}, 0);
        step();
        chk("mis_err", {RSP_VALID, RSP_ERR}, 2'b11);
        chk("mis_rdata", RSP_RDATA, 0);

        // Reset in the store's issue cycle.
        C_VALID = 1; C_WE = 1; C_FUNCT3 = 3'd2; C_ADDR = 13'h020; C_WDATA = 32'hCAFEF00D;
        RST = 1;
        step();
        chk("rst_store_we", LANE_WE, 0);
        RST = 0; C_VALID = 0;
        step();
        chk("rst_store_rsp", RSP_VALID, 0);
        issue_c(0, 3'd2, 13'h020, 0);
        step();
        chk("rst_store_mem", RSP_RDATA, 0);

        // Reset drops a pending response.
        issue_c(0, 3'd2, 13'h010, 0);
        RST = 1;
        step();
        chk("rst_drop_rsp", RSP_VALID, 0);
        RST = 0;
        step();

        // Both ports valid for four cycles.
`ifdef DMEM_CTRL_RR_EN
        exp_ids = 4'b1010;
`else
        exp_ids = 4'b0000;
`endif
        C_VALID = 1; C_WE = 0; C_FUNCT3 = 3'd2; C_ADDR = 13'h010;
        L_VALID = 1; L_WE = 0; L_FUNCT3 = 3'd2; L_ADDR = 13'h014;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                C_VALID = 0; L_VALID = 0;
            end else begin
                #1;
                chk("arb_c_ready", C_READY, !exp_ids[i]);
            end
            step();
            if (i > 0) chk("arb_rsp_id", RSP_ID, exp_ids[i-1]);
        end

        // Randomized traffic on both ports.
        for (int n = 0; n < 3000; n++) begin
            RST = ($urandom_range(0, 99) == 0);
            C_VALID = ($urandom_range(0, 9) < 6);
            L_VALID = ($urandom_range(0, 9) < 5);
            C_WE = $urandom_range(0, 1);
            L_WE = $urandom_range(0, 1);
            C_FUNCT3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : legal_f3[$urandom_range(0, 4)];
            L_FUNCT3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : legal_f3[$urandom_range(0, 4)];
            C_ADDR = 13'($urandom_range(0, 63));
            L_ADDR = ($urandom_range(0, 7) == 0) ? 13'($urandom_range(0, 8191 - 4)) : 13'($urandom_range(0, 63));
            C_WDATA = $urandom;
            L_WDATA = $urandom;
            step();
        end
        RST = 0; C_VALID = 0; L_VALID = 0;
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
